// File: rtl/fsk_demod_pkg.sv
// Shared constants and types for the FSK demodulator. The tone table uses the
// same values as the modulator: cos[n] scaled to 13-bit two's complement.
package fsk_demod_pkg;

    localparam int PHASE_RES = 3;                 // log2(samples per symbol)
    localparam int SIN_SIZE  = 13;                // sample / LUT width
    localparam int PROD_W    = 2 * SIN_SIZE;      // full-precision product width

    typedef logic [PHASE_RES-1:0]       phase_t;
    typedef logic signed [SIN_SIZE-1:0] samp_t;
    typedef logic signed [PROD_W-1:0]   prod_t;

    // The four stage-1 products of one sample against the reference tone.
    typedef struct packed {
        prod_t ic;   // I * cos
        prod_t qs;   // Q * sin
        prod_t qc;   // Q * cos
        prod_t is;   // I * sin
    } prod4_t;

    // cos(n * pi/4) * 4095, rounded as in the modulator table.
    function automatic samp_t cos_lut(input phase_t ph);
        samp_t v;
        case (ph)
            3'd0:    v =  13'sd4095;
            3'd1:    v =  13'sd2896;
            3'd2:    v =  13'sd0;
            3'd3:    v = -13'sd2896;
            3'd4:    v = -13'sd4095;
            3'd5:    v = -13'sd2896;
            3'd6:    v =  13'sd0;
            default: v =  13'sd2896;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/fsk_demod_tone_lut.sv
// Reference tone lookup: cos and sin of phase * pi/4, combinational.
// sin is the cos table shifted by a quarter turn (two phase steps).
module tone_lut
    import fsk_demod_pkg::*;
(
    input  logic [PHASE_RES-1:0] phase_i,
    output logic [SIN_SIZE-1:0]  cos_o,
    output logic [SIN_SIZE-1:0]  sin_o
);

    // Phase arithmetic wraps naturally in PHASE_RES bits.
    assign cos_o = cos_lut(phase_i);
    assign sin_o = cos_lut(phase_i - phase_t'(2));

endmodule

// File: rtl/fsk_demod.sv
// Non-coherent FSK bit detector: correlates each 8-sample symbol with the
// +tone and -tone references and decides on the larger |Re|+|Im| magnitude.
// Pipeline: stage 1 products, stage 2 accumulate, stage 3 decide.
module fsk_demod
    import fsk_demod_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [SIN_SIZE-1:0] i_in,
    input  logic [SIN_SIZE-1:0] q_in,
    input  logic                sym_start,
    output logic                bit_valid,
    output logic                bit_out
);

    localparam int EXT = ACC_W - PROD_W;

    // Sample index counter
    phase_t n_q, n_d, idx;

    // Stage 1
    logic   s1_vld_q, s1_first_q, s1_last_q;
    prod4_t s1_prod_q, prod_d;

    // Stage 2
    logic signed [ACC_W-1:0] re1_q, im1_q, re0_q, im0_q;
    logic signed [ACC_W-1:0] re1_d, im1_d, re0_d, im0_d;
    logic signed [ACC_W-1:0] x_ic, x_qs, x_qc, x_is;
    logic                    s2_done_q;

    // Stage 3
    logic [ACC_W-1:0] a_re1, a_im1, a_re0, a_im0;
    logic [ACC_W:0]   m1, m0;
    logic             bv_q, bit_q;

    // Tone reference, driven by the effective index of the incoming sample
    logic signed [SIN_SIZE-1:0] cos_w, sin_w;

    // sym_start forces the current sample to index 0
    always_comb begin
        idx = sym_start ? phase_t'(0) : n_q;
        n_d = n_q;
        if (in_valid) n_d = idx + phase_t'(1);
    end

    tone_lut u_lut (
        .phase_i (idx),
        .cos_o   (cos_w),
        .sin_o   (sin_w)
    );

    // Sample index register; holds across in_valid gaps
    always_ff @(posedge clk) begin
        if (rst) n_q <= '0;
        else     n_q <= n_d;
    end

    // Stage 1 multiplier inputs
    always_comb begin
        prod_d.ic = $signed(i_in) * cos_w;
        prod_d.qs = $signed(q_in) * sin_w;
        prod_d.qc = $signed(q_in) * cos_w;
        prod_d.is = $signed(i_in) * sin_w;
    end

    // Stage 1: register products with their first/last flags
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_prod_q  <= '0;
        end else begin
            s1_vld_q <= in_valid;
            if (in_valid) begin
                s1_first_q <= (idx == phase_t'(0));
                s1_last_q  <= (idx == phase_t'(7));
                s1_prod_q  <= prod_d;
            end
        end
    end

    assign x_ic = {{EXT{s1_prod_q.ic[PROD_W-1]}}, s1_prod_q.ic};
    assign x_qs = {{EXT{s1_prod_q.qs[PROD_W-1]}}, s1_prod_q.qs};
    assign x_qc = {{EXT{s1_prod_q.qc[PROD_W-1]}}, s1_prod_q.qc};
    assign x_is = {{EXT{s1_prod_q.is[PROD_W-1]}}, s1_prod_q.is};

    // Stage 2 next-state: a first-flagged product restarts the sums
    always_comb begin
        re1_d = re1_q;
        im1_d = im1_q;
        re0_d = re0_q;
        im0_d = im0_q;
        if (s1_vld_q) begin
            re1_d = (s1_first_q ? '0 : re1_q) + x_ic + x_qs;
            im1_d = (s1_first_q ? '0 : im1_q) + x_qc - x_is;
            re0_d = (s1_first_q ? '0 : re0_q) + x_ic - x_qs;
            im0_d = (s1_first_q ? '0 : im0_q) + x_qc + x_is;
        end
    end

    // Stage 2: accumulators and symbol-complete flag
    always_ff @(posedge clk) begin
        if (rst) begin
            re1_q     <= '0;
            im1_q     <= '0;
            re0_q     <= '0;
            im0_q     <= '0;
            s2_done_q <= 1'b0;
        end else begin
            re1_q     <= re1_d;
            im1_q     <= im1_d;
            re0_q     <= re0_d;
            im0_q     <= im0_d;
            s2_done_q <= s1_vld_q & s1_last_q;
        end
    end

    // Stage 3 magnitudes; the decision is registered on the same edge that may
    // reload the accumulators for the next symbol, so it sees the completed sums
    always_comb begin
        a_re1 = re1_q[ACC_W-1] ? -re1_q : re1_q;
        a_im1 = im1_q[ACC_W-1] ? -im1_q : im1_q;
        a_re0 = re0_q[ACC_W-1] ? -re0_q : re0_q;
        a_im0 = im0_q[ACC_W-1] ? -im0_q : im0_q;
        m1    = {1'b0, a_re1} + {1'b0, a_im1};
        m0    = {1'b0, a_re0} + {1'b0, a_im0};
    end

    // Stage 3: hard decision, ties resolve to 0
    always_ff @(posedge clk) begin
        if (rst) begin
            bv_q  <= 1'b0;
            bit_q <= 1'b0;
        end else begin
            bv_q <= s2_done_q;
            if (s2_done_q) bit_q <= (m1 > m0);
        end
    end

    // Suppress the pulse in the cycle rst is raised so no bit escapes after it
    assign bit_valid = bv_q & ~rst;
    assign bit_out   = bit_q;

endmodule
